// File: rtl/logic_vec_unit_if.sv
// Valid/ready bundle for logic_vec_unit: the operand beat stream and the result stream.
interface logic_vec_unit_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             out_zero;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, op, x, y, last, out_ready,
    input  in_ready, out_valid, out, out_zero, out_count
  );

  modport slave (
    input  in_valid, op, x, y, last, out_ready,
    output in_ready, out_valid, out, out_zero, out_count
  );
endinterface

// File: rtl/logic_vec_unit.sv
// Registered bitwise logic unit with OR/XOR burst reduction; results appear at the accepting edge.
// Backpressure: in_ready = !out_valid || out_ready, so a full unheld output register stalls input.
module logic_vec_unit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input logic             clk,
  input logic             rst_n,
  logic_vec_unit_if.slave bus
);
  typedef enum logic {IDLE, ACCUM} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             burst_xor_q, burst_xor_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_zero_q, out_zero_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;

  logic             in_ready;
  logic             fire;
  logic [WIDTH-1:0] op_res;
  logic [WIDTH-1:0] fold;
  logic [CNT_W-1:0] cnt_inc;

  assign in_ready = !out_valid_q || bus.out_ready;
  assign fire     = bus.in_valid && in_ready;
  assign cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
  assign fold     = burst_xor_q ? (acc_q ^ bus.x) : (acc_q | bus.x);

  always_comb begin
    op_res = '0;
    case (bus.op)
      3'd0:    op_res = bus.x & bus.y;
      3'd1:    op_res = bus.x | bus.y;
      3'd2:    op_res = bus.x ^ bus.y;
      3'd3:    op_res = ~(bus.x | bus.y);
      3'd4:    op_res = ~(bus.x & bus.y);
      3'd5:    op_res = ~(bus.x ^ bus.y);
      default: op_res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    burst_xor_d = burst_xor_q;
    out_d       = out_q;
    out_zero_d  = out_zero_q;
    out_count_d = out_count_q;
    // A load below overrides the drain, giving back-to-back results.
    out_valid_d = out_valid_q && !bus.out_ready;

    if (fire) begin
      case (state_q)
        IDLE: begin
          if (bus.op < 3'd6) begin
            out_d       = op_res;
            out_zero_d  = (op_res == '0);
            out_count_d = CNT_W'(1);
            out_valid_d = 1'b1;
          end else if (bus.last) begin
            out_d       = bus.x;
            out_zero_d  = (bus.x == '0);
            out_count_d = CNT_W'(1);
            out_valid_d = 1'b1;
          end else begin
            acc_d       = bus.x;
            cnt_d       = CNT_W'(1);
            burst_xor_d = bus.op[0];
            state_d     = ACCUM;
          end
        end
        ACCUM: begin
          acc_d = fold;
          cnt_d = cnt_inc;
          if (bus.last) begin
            out_d       = fold;
            out_zero_d  = (fold == '0);
            out_count_d = cnt_inc;
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      burst_xor_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      out_zero_q  <= 1'b0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      burst_xor_q <= burst_xor_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      out_zero_q  <= out_zero_d;
      out_count_q <= out_count_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.out_zero  = out_zero_q;
  assign bus.out_count = out_count_q;
endmodule

// File: tb/tb_logic_vec_unit.sv
// Drives two logic_vec_unit instances (CNT_W 8 and 2) with identical beats and checks both against one model.
module tb_logic_vec_unit;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [2:0]   op;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         last;
  logic         out_ready;

  always #5 clk = ~clk;

  logic_vec_unit_if #(.WIDTH(W), .CNT_W(8)) b8 ();
  logic_vec_unit_if #(.WIDTH(W), .CNT_W(2)) b2 ();

  assign b8.in_valid  = in_valid;
  assign b8.op        = op;
  assign b8.x         = x;
  assign b8.y         = y;
  assign b8.last      = last;
  assign b8.out_ready = out_ready;
  assign b2.in_valid  = in_valid;
  assign b2.op        = op;
  assign b2.x         = x;
  assign b2.y         = y;
  assign b2.last      = last;
  assign b2.out_ready = out_ready;

  logic_vec_unit #(.WIDTH(W), .CNT_W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  logic_vec_unit #(.WIDTH(W), .CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  int n_chk = 0;
  int n_bad = 0;

  // Reference state: the visible output register plus the burst held as a list of operands.
  bit           m_valid = 1'b0;
  logic [W-1:0] m_out   = '0;
  bit           m_zero  = 1'b0;
  int           m_cnt   = 0;
  bit           m_burst = 1'b0;
  bit           m_bxor  = 1'b0;
  logic [W-1:0] bq[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] bitop(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    case (o)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a | b);
      3'd4:    return ~(a & b);
      default: return ~(a ^ b);
    endcase
  endfunction

  function automatic logic [W-1:0] fold_burst();
    logic [W-1:0] r = '0;
    foreach (bq[i]) r = m_bxor ? (r ^ bq[i]) : (r | bq[i]);
    return r;
  endfunction

  function automatic int sat(input int n, input int cw);
    int lim = (1 << cw) - 1;
    return (n > lim) ? lim : n;
  endfunction

  task automatic load(input logic [W-1:0] v, input int n);
    m_valid = 1'b1;
    m_out   = v;
    m_zero  = (v == '0);
    m_cnt   = n;
  endtask

  // One clock: check in_ready before the edge, advance the model at the edge, check outputs after it.
  task automatic cycle();
    bit rdy, fire;
    @(negedge clk);
    rdy = !m_valid || out_ready;
    if (rst_n) begin
      chk("in_ready8", {31'd0, b8.in_ready}, {31'd0, rdy});
      chk("in_ready2", {31'd0, b2.in_ready}, {31'd0, rdy});
    end
    fire = rst_n && in_valid && rdy;
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 1'b0; m_out = '0; m_zero = 1'b0; m_cnt = 0;
      m_burst = 1'b0; bq.delete();
    end else begin
      if (m_valid && out_ready) m_valid = 1'b0;
      if (fire) begin
        if (!m_burst && op < 3'd6) begin
          load(bitop(op, x, y), 1);
        end else begin
          if (!m_burst) begin
            m_bxor  = op[0];
            m_burst = 1'b1;
          end
          bq.push_back(x);
          if (last) begin
            load(fold_burst(), bq.size());
            bq.delete();
            m_burst = 1'b0;
          end
        end
      end
    end
    #1;
    chk("out_valid8", {31'd0, b8.out_valid}, {31'd0, m_valid});
    chk("out8",       {16'd0, b8.out},       {16'd0, m_out});
    chk("out_zero8",  {31'd0, b8.out_zero},  {31'd0, m_zero});
    chk("out_count8", {24'd0, b8.out_count}, sat(m_cnt, 8));
    chk("out_valid2", {31'd0, b2.out_valid}, {31'd0, m_valid});
    chk("out2",       {16'd0, b2.out},       {16'd0, m_out});
    chk("out_zero2",  {31'd0, b2.out_zero},  {31'd0, m_zero});
    chk("out_count2", {30'd0, b2.out_count}, sat(m_cnt, 2));
  endtask

  task automatic beat(input bit v, input logic [2:0] o, input logic [W-1:0] a,
                      input logic [W-1:0] b, input bit l, input bit ordy);
    in_valid  = v;
    op        = o;
    x         = a;
    y         = b;
    last      = l;
    out_ready = ordy;
    cycle();
  endtask

  logic [W-1:0] tbl [6];
  logic [W-1:0] sat_or;

  initial begin
    tbl = '{16'h00F0, 16'hFFF0, 16'hFF00, 16'h000F, 16'hFF0F, 16'h00FF};
    rst_n = 1'b0;
    in_valid = 1'b0; op = '0; x = '0; y = '0; last = 1'b0; out_ready = 1'b0;
    repeat (2) cycle();
    rst_n = 1'b1;

    // Single-beat ops at full rate.
    for (int i = 0; i < 6; i++) begin
      beat(1, 3'(i), 16'hF0F0, 16'h0FF0, 0, 1);
      chk("tbl_out", {16'd0, b8.out}, {16'd0, tbl[i]});
      chk("tbl_cnt", {24'd0, b8.out_count}, 32'd1);
    end

    // RED_OR burst; op changes mid-burst and must be ignored.
    beat(1, 3'd6, 16'h0001, 16'hFFFF, 0, 1);
    beat(1, 3'd0, 16'h0010, 16'hFFFF, 0, 1);
    beat(1, 3'd0, 16'h0100, 16'hFFFF, 0, 1);
    beat(1, 3'd0, 16'h1000, 16'hFFFF, 1, 1);
    chk("redor_out", {16'd0, b8.out}, 32'h1111);
    chk("redor_cnt", {24'd0, b8.out_count}, 32'd4);
    beat(0, 3'd0, 16'h0, 16'h0, 0, 1);

    // Backpressure: three stalled cycles, then drain and load on one edge.
    beat(1, 3'd1, 16'h1200, 16'h0034, 0, 1);
    for (int i = 0; i < 3; i++) begin
      beat(1, 3'd2, 16'h5555, 16'h00FF, 0, 0);
      chk("bp_hold", {16'd0, b8.out}, 32'h1234);
    end
    beat(1, 3'd2, 16'h5555, 16'h00FF, 0, 1);
    chk("bp_next", {16'd0, b8.out}, 32'h55AA);
    chk("bp_vld", {31'd0, b8.out_valid}, 32'd1);

    // RED_XOR cancelling to zero, then a single-beat RED_XOR.
    beat(1, 3'd7, 16'hAAAA, 16'h0, 0, 1);
    beat(1, 3'd7, 16'hAAAA, 16'h0, 1, 1);
    chk("rx_zero", {31'd0, b8.out_zero}, 32'd1);
    chk("rx_cnt", {24'd0, b8.out_count}, 32'd2);
    beat(1, 3'd7, 16'h1234, 16'h0, 1, 1);
    chk("rx1_out", {16'd0, b8.out}, 32'h1234);
    chk("rx1_cnt", {24'd0, b8.out_count}, 32'd1);

    // Reset in the middle of a burst.
    beat(1, 3'd6, 16'h0F00, 16'h0, 0, 1);
    beat(1, 3'd6, 16'h00F0, 16'h0, 0, 1);
    rst_n = 1'b0;
    beat(1, 3'd6, 16'h8000, 16'h0, 0, 1);
    chk("rst_vld", {31'd0, b8.out_valid}, 32'd0);
    rst_n = 1'b1;
    beat(1, 3'd6, 16'h0002, 16'h0, 1, 1);
    chk("post_rst_out", {16'd0, b8.out}, 32'h0002);
    chk("post_rst_cnt", {24'd0, b8.out_count}, 32'd1);

    // Five-beat RED_OR: the CNT_W=2 instance saturates at 3.
    sat_or = '0;
    for (int i = 0; i < 5; i++) begin
      x = W'($urandom);
      sat_or = sat_or | x;
      beat(1, 3'd6, x, 16'h0, i == 4, 1);
    end
    chk("sat2_cnt", {30'd0, b2.out_count}, 32'd3);
    chk("sat2_out", {16'd0, b2.out}, {16'd0, sat_or});
    chk("sat8_cnt", {24'd0, b8.out_count}, 32'd5);

    // Long RED_XOR burst past the 8-bit counter limit.
    for (int i = 0; i < 300; i++) beat(1, 3'd7, W'($urandom), W'($urandom), i == 299, 1);
    chk("sat8_long", {24'd0, b8.out_count}, 32'd255);

    // Random traffic with gaps, stalls and bursts.
    for (int i = 0; i < 4000; i++) begin
      beat($urandom_range(0, 3) != 0, 3'($urandom), W'($urandom), W'($urandom),
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
    end
    beat(0, 3'd0, 16'h0, 16'h0, 0, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
